// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM frame-buffer arbiter.
// Holds the arbiter state encoding, grant encoding, bus widths, default
// parameter values and the burst-length helper used by both address
// generators.
package sdram_arb_pkg;

  localparam int ADDR_W  = 22;
  localparam int LEN_W   = 9;
  localparam int USEDW_W = 10;

  localparam int                DEF_BURST_LEN   = 256;
  localparam int                DEF_FRAME_WORDS = 76800;
  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR   = 22'd0;
  localparam int                DEF_RD_THRESH   = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_REQ   = 3'd1,
    ST_WR_BURST = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_RD_BURST = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // Words left before the end of the frame, capped at the burst size, so
  // the final burst of a frame is shortened instead of running past it.
  function automatic logic [LEN_W-1:0] burst_len_f(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W:0]   frame_end,
    input logic [ADDR_W:0]   burst_max
  );
    logic [ADDR_W:0] remain_s;
    remain_s = frame_end - {1'b0, addr};
    if (remain_s < burst_max) begin
      return LEN_W'(remain_s);
    end else begin
      return LEN_W'(burst_max);
    end
  endfunction

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// Burst request bus between the frame arbiter and the SDRAM controller.
//   sdram_wr_req / sdram_rd_req : burst requests (arbiter -> controller)
//   sdram_wr_ack / sdram_rd_ack : high for the whole data phase (controller -> arbiter)
//   sys_wraddr / sys_rdaddr     : burst start word addresses
//   sdwr_byte / sdrd_byte       : burst lengths in words
interface sdram_frame_arbiter_if;
  import sdram_arb_pkg::*;

  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [ADDR_W-1:0] sys_wraddr;
  logic [ADDR_W-1:0] sys_rdaddr;
  logic [LEN_W-1:0]  sdwr_byte;
  logic [LEN_W-1:0]  sdrd_byte;

  modport master (
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    output sdram_wr_ack, sdram_rd_ack
  );

endinterface

// File: rtl/sdram_addr_gen.sv
// Per-side frame-buffer address generator.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_sync   : one-cycle frame start pulse for this side
//   side_active  : this side is in its REQ or BURST state
//   burst_done   : this side's burst completes this cycle
//   addr, len    : registered burst start address and burst length
// Address and length only change at burst completion or on a sync while the
// side is inactive, so they stay stable for a whole request/burst.
module sdram_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_sync,
  input  logic              side_active,
  input  logic              burst_done,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len
);

  localparam logic [ADDR_W:0] FRAME_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0] BURST_MAX = (ADDR_W+1)'(BURST_LEN);

  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_r;
  logic              pend_r;
  logic [ADDR_W:0]   sum_s;
  logic [ADDR_W-1:0] adv_addr_s;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic              load_s;

  // Next address: advance with wrap, or jump to base on a pending/current sync.
  always_comb begin
    sum_s      = {1'b0, addr_r} + {{(ADDR_W+1-LEN_W){1'b0}}, len_r};
    adv_addr_s = addr_r;
    nxt_addr_s = addr_r;
    load_s     = 1'b0;
    if (sum_s >= FRAME_END) begin
      adv_addr_s = BASE_ADDR;
    end else begin
      adv_addr_s = sum_s[ADDR_W-1:0];
    end
    if (burst_done) begin
      load_s     = 1'b1;
      nxt_addr_s = (pend_r || frame_sync) ? BASE_ADDR : adv_addr_s;
    end else if (frame_sync && !side_active) begin
      load_s     = 1'b1;
      nxt_addr_s = BASE_ADDR;
    end else begin
      load_s     = 1'b0;
      nxt_addr_s = addr_r;
    end
  end

  // Address, length and pending-sync registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= BASE_ADDR;
      len_r  <= burst_len_f(BASE_ADDR, FRAME_END, BURST_MAX);
      pend_r <= 1'b0;
    end else begin
      if (load_s) begin
        addr_r <= nxt_addr_s;
        len_r  <= burst_len_f(nxt_addr_s, FRAME_END, BURST_MAX);
      end
      if (burst_done) begin
        pend_r <= 1'b0;
      end else if (frame_sync && side_active) begin
        pend_r <= 1'b1;
      end
    end
  end

  assign addr = addr_r;
  assign len  = len_r;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates SDRAM bursts between a camera write FIFO and a display read FIFO.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   sdram_init_done                : SDRAM ready; arbitration held off until set
//   wr_fifo_usedw / rd_fifo_usedw  : FIFO fill levels
//   wr_frame_sync / rd_frame_sync  : frame start pulses, restart that side at base
//   sdram_bus (master)             : request/ack/address/length bus to controller
//   arb_busy                       : registered, high whenever not IDLE
// Ties are broken by alternating against the last completed grant.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int                RD_THRESH   = DEF_RD_THRESH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdram_init_done,
  input  logic [USEDW_W-1:0]   wr_fifo_usedw,
  input  logic [USEDW_W-1:0]   rd_fifo_usedw,
  input  logic                 wr_frame_sync,
  input  logic                 rd_frame_sync,
  sdram_frame_arbiter_if.master sdram_bus,
  output logic                 arb_busy
);

  arb_state_e        state_r;
  grant_e            last_grant_r;
  logic              wr_req_r;
  logic              rd_req_r;
  logic              busy_r;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [LEN_W-1:0]  wr_len_s;
  logic [LEN_W-1:0]  rd_len_s;
  logic              wr_need_s;
  logic              rd_need_s;
  logic              wr_done_s;
  logic              rd_done_s;
  logic              wr_active_s;
  logic              rd_active_s;

  assign wr_need_s   = wr_fifo_usedw >= {1'b0, wr_len_s};
  assign rd_need_s   = rd_fifo_usedw < USEDW_W'(RD_THRESH);
  assign wr_done_s   = (state_r == ST_WR_BURST) && !sdram_bus.sdram_wr_ack;
  assign rd_done_s   = (state_r == ST_RD_BURST) && !sdram_bus.sdram_rd_ack;
  assign wr_active_s = (state_r == ST_WR_REQ) || (state_r == ST_WR_BURST);
  assign rd_active_s = (state_r == ST_RD_REQ) || (state_r == ST_RD_BURST);

  sdram_addr_gen #(
    .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .frame_sync(wr_frame_sync), .side_active(wr_active_s),
    .burst_done(wr_done_s), .addr(wr_addr_s), .len(wr_len_s)
  );

  sdram_addr_gen #(
    .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS), .BASE_ADDR(BASE_ADDR)
  ) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .frame_sync(rd_frame_sync), .side_active(rd_active_s),
    .burst_done(rd_done_s), .addr(rd_addr_s), .len(rd_len_s)
  );

  // Arbitration FSM with registered requests, busy flag and last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wr_req_r     <= 1'b0;
      rd_req_r     <= 1'b0;
      busy_r       <= 1'b0;
      last_grant_r <= GRANT_WR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Write wins when it alone needs service, or on a tie after a read.
          if (sdram_init_done && wr_need_s && (!rd_need_s || last_grant_r == GRANT_RD)) begin
            state_r <= ST_WR_REQ;
            busy_r  <= 1'b1;
          end else if (sdram_init_done && rd_need_s) begin
            state_r <= ST_RD_REQ;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_WR_REQ: begin
          if (sdram_bus.sdram_wr_ack) begin
            state_r  <= ST_WR_BURST;
            wr_req_r <= 1'b0;
          end else begin
            wr_req_r <= 1'b1;
          end
        end
        ST_WR_BURST: begin
          if (!sdram_bus.sdram_wr_ack) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= GRANT_WR;
          end else begin
            state_r <= ST_WR_BURST;
          end
        end
        ST_RD_REQ: begin
          if (sdram_bus.sdram_rd_ack) begin
            state_r  <= ST_RD_BURST;
            rd_req_r <= 1'b0;
          end else begin
            rd_req_r <= 1'b1;
          end
        end
        ST_RD_BURST: begin
          if (!sdram_bus.sdram_rd_ack) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= GRANT_RD;
          end else begin
            state_r <= ST_RD_BURST;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          wr_req_r <= 1'b0;
          rd_req_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign sdram_bus.sdram_wr_req = wr_req_r;
  assign sdram_bus.sdram_rd_req = rd_req_r;
  assign sdram_bus.sys_wraddr   = wr_addr_s;
  assign sdram_bus.sys_rdaddr   = rd_addr_s;
  assign sdram_bus.sdwr_byte    = wr_len_s;
  assign sdram_bus.sdrd_byte    = rd_len_s;
  assign arb_busy               = busy_r;

endmodule
